// File: rtl/rgb_to_ycbcr_pipe.sv
// rtl/rgb_to_ycbcr_pipe.sv - 4-stage RGB->YCbCr converter, per-frame matrix select, valid/ready stall.
// Optional limited-range clamp of output components when RGB2YCC_LIMIT_CLAMP_EN is defined.
module rgb_to_ycbcr_pipe #(
    parameter int DW           = 8,
    parameter int MODE_DEFAULT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_r,
    input  logic [DW-1:0] i_g,
    input  logic [DW-1:0] i_b,
    input  logic          i_h_sync,
    input  logic          i_v_sync,
    input  logic          i_data_en,
    input  logic [1:0]    i_mode,
    input  logic          i_valid,
    output logic          o_in_ready,
    output logic [DW-1:0] o_y,
    output logic [DW-1:0] o_cb,
    output logic [DW-1:0] o_cr,
    output logic          o_h_sync,
    output logic          o_v_sync,
    output logic          o_data_en,
    output logic [1:0]    o_mode,
    output logic          o_valid,
    input  logic          i_out_ready
);
    localparam int PW = DW + 8;
    localparam int SW = DW + 10;
    localparam logic [DW-1:0] MAX_VAL = {DW{1'b1}};
    localparam logic [SW-1:0] Y_OFF   = SW'(16) << DW;
    localparam logic [SW-1:0] C_OFF   = SW'(128) << DW;
`ifdef RGB2YCC_LIMIT_CLAMP_EN
    localparam logic [DW-1:0] LIM_LO   = DW'(16) << (DW - 8);
    localparam logic [DW-1:0] LIM_Y_HI = DW'(235) << (DW - 8);
    localparam logic [DW-1:0] LIM_C_HI = DW'(240) << (DW - 8);
`endif

    typedef enum logic [1:0] {M_709 = 2'd0, M_601 = 2'd1, M_JPEG = 2'd2, M_RSVD = 2'd3} mode_t;

    typedef struct packed {
        logic  hs;
        logic  vs;
        logic  de;
        mode_t mode;
        logic  valid;
    } meta_t;

    logic          en, take, frame_start, prev_vs, next_prev_vs;
    mode_t         active_mode, next_mode;
    logic [8:0]    coef [9];
    logic [DW-1:0] rgb [3];
    logic [PW-1:0] s1_p [9];
    meta_t         m1, m2, m3;
    logic [SW-1:0] s2_y, s2_cb_p, s2_cb_n, s2_cr_p, s2_cr_n;
    logic [SW-1:0] s3_y, s3_cb, s3_cr;
    logic [DW-1:0] y_fin, cb_fin, cr_fin;

    function automatic logic [SW-1:0] pos_diff(input logic [SW-1:0] a, input logic [SW-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    function automatic logic [DW-1:0] round_sat(input logic [SW-1:0] v);
        logic [SW-1:0] q;
        q = (v + SW'(128)) >> 8;
        return (q > SW'(MAX_VAL)) ? MAX_VAL : q[DW-1:0];
    endfunction

`ifdef RGB2YCC_LIMIT_CLAMP_EN
    function automatic logic [DW-1:0] limit(input logic [DW-1:0] v, input logic [DW-1:0] lo,
                                            input logic [DW-1:0] hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction
`endif

    assign en         = i_out_ready | ~o_valid;
    assign o_in_ready = en;
    assign take       = i_valid & en;

    // The frame-start beat itself already carries the newly requested matrix.
    always_comb begin
        frame_start  = take & i_v_sync & ~prev_vs;
        next_mode    = frame_start ? mode_t'(i_mode) : active_mode;
        next_prev_vs = take ? i_v_sync : prev_vs;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_mode <= mode_t'(2'(MODE_DEFAULT));
            prev_vs     <= 1'b0;
        end else begin
            active_mode <= next_mode;
            prev_vs     <= next_prev_vs;
        end
    end

    always_comb begin
        rgb  = '{i_r, i_g, i_b};
        coef = '{9'd47, 9'd157, 9'd16, 9'd26, 9'd86, 9'd112, 9'd112, 9'd102, 9'd10};
        case (next_mode)
            M_601:   coef = '{9'd66, 9'd129, 9'd25, 9'd38, 9'd74, 9'd112, 9'd112, 9'd94, 9'd18};
            M_JPEG:  coef = '{9'd77, 9'd150, 9'd29, 9'd43, 9'd85, 9'd128, 9'd128, 9'd107, 9'd21};
            default: ;
        endcase
    end

    always_comb begin
        y_fin  = round_sat(s3_y);
        cb_fin = round_sat(s3_cb);
        cr_fin = round_sat(s3_cr);
`ifdef RGB2YCC_LIMIT_CLAMP_EN
        if (m3.mode != M_JPEG) begin
            y_fin  = limit(y_fin, LIM_LO, LIM_Y_HI);
            cb_fin = limit(cb_fin, LIM_LO, LIM_C_HI);
            cr_fin = limit(cr_fin, LIM_LO, LIM_C_HI);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) s1_p[k] <= '0;
            m1 <= '0; m2 <= '0; m3 <= '0;
            s2_y <= '0; s2_cb_p <= '0; s2_cb_n <= '0; s2_cr_p <= '0; s2_cr_n <= '0;
            s3_y <= '0; s3_cb <= '0; s3_cr <= '0;
            o_y <= '0; o_cb <= '0; o_cr <= '0;
            o_h_sync <= 1'b0; o_v_sync <= 1'b0; o_data_en <= 1'b0;
            o_mode <= 2'd0; o_valid <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < 9; k++) s1_p[k] <= PW'(rgb[k % 3]) * PW'(coef[k]);
            m1.hs    <= i_h_sync;
            m1.vs    <= i_v_sync;
            m1.de    <= i_data_en;
            m1.mode  <= next_mode;
            m1.valid <= i_valid;

            // Chroma terms split into positive and negative sums so nothing goes signed.
            s2_y    <= SW'(s1_p[0]) + SW'(s1_p[1]) + SW'(s1_p[2]) +
                       ((m1.mode == M_JPEG) ? SW'(0) : Y_OFF);
            s2_cb_p <= SW'(s1_p[5]) + C_OFF;
            s2_cb_n <= SW'(s1_p[3]) + SW'(s1_p[4]);
            s2_cr_p <= SW'(s1_p[6]) + C_OFF;
            s2_cr_n <= SW'(s1_p[7]) + SW'(s1_p[8]);
            m2      <= m1;

            s3_y  <= s2_y;
            s3_cb <= pos_diff(s2_cb_p, s2_cb_n);
            s3_cr <= pos_diff(s2_cr_p, s2_cr_n);
            m3    <= m2;

            o_y       <= y_fin;
            o_cb      <= cb_fin;
            o_cr      <= cr_fin;
            o_h_sync  <= m3.hs;
            o_v_sync  <= m3.vs;
            o_data_en <= m3.de;
            o_mode    <= m3.mode;
            o_valid   <= m3.valid;
        end
    end
endmodule

// File: tb/tb_rgb_to_ycbcr_pipe.sv
// tb/tb_rgb_to_ycbcr_pipe.sv - scoreboard bench for rgb_to_ycbcr_pipe (DW=8, MODE_DEFAULT=0).
module tb_rgb_to_ycbcr_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_r = '0, i_g = '0, i_b = '0;
    logic       i_h_sync = 1'b0, i_v_sync = 1'b0, i_data_en = 1'b0;
    logic [1:0] i_mode = '0;
    logic       i_valid = 1'b0;
    logic       i_out_ready = 1'b1;
    logic       o_in_ready;
    logic [7:0] o_y, o_cb, o_cr;
    logic       o_h_sync, o_v_sync, o_data_en;
    logic [1:0] o_mode;
    logic       o_valid;

    rgb_to_ycbcr_pipe #(.DW(8), .MODE_DEFAULT(0)) dut (
        .clk(clk), .rst(rst), .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .i_h_sync(i_h_sync), .i_v_sync(i_v_sync), .i_data_en(i_data_en),
        .i_mode(i_mode), .i_valid(i_valid), .o_in_ready(o_in_ready),
        .o_y(o_y), .o_cb(o_cb), .o_cr(o_cr),
        .o_h_sync(o_h_sync), .o_v_sync(o_v_sync), .o_data_en(o_data_en),
        .o_mode(o_mode), .o_valid(o_valid), .i_out_ready(i_out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   y, cb, cr, mode, lat;
        logic hs, vs, de;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ref_mode = 0;
    bit   ref_prev_vs = 1'b0;
    int   stall_cnt = 0;
    bit   rand_ready = 1'b0;
    bit   check_lat = 1'b0;

    always @(posedge clk) cyc++;

    function automatic int component(int raw, int lo, int hi);
        int v;
        if (raw < 0) raw = 0;
        v = (raw + 128) / 256;
        if (v > 255) v = 255;
        if (v < lo) v = lo;
        if (v > hi) v = hi;
        return v;
    endfunction

    function automatic exp_t model(int r, int g, int b, logic hs, logic vs, logic de, int m);
        int   t[9];
        int   yoff, lo, yhi, chi;
        exp_t e;
        case (m)
            1:       t = '{66, 129, 25, 38, 74, 112, 112, 94, 18};
            2:       t = '{77, 150, 29, 43, 85, 128, 128, 107, 21};
            default: t = '{47, 157, 16, 26, 86, 112, 112, 102, 10};
        endcase
        yoff = (m == 2) ? 0 : 16;
        lo = 0; yhi = 255; chi = 255;
`ifdef RGB2YCC_LIMIT_CLAMP_EN
        if (m != 2) begin lo = 16; yhi = 235; chi = 240; end
`endif
        e.y    = component(t[0]*r + t[1]*g + t[2]*b + yoff*256, lo, yhi);
        e.cb   = component(-t[3]*r - t[4]*g + t[5]*b + 128*256, lo, chi);
        e.cr   = component(t[6]*r - t[7]*g - t[8]*b + 128*256, lo, chi);
        e.mode = m;
        e.hs = hs; e.vs = vs; e.de = de;
        e.lat  = -1;
        return e;
    endfunction

    function automatic bit next_ready();
        if (stall_cnt > 0) begin
            stall_cnt--;
            return 1'b0;
        end
        return rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    task automatic send(input int r, input int g, input int b, input logic hs, input logic vs,
                        input logic de, input int m, input int ey = -1, input int ecb = -1,
                        input int ecr = -1, input int em = -1);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        i_r = 8'(r); i_g = 8'(g); i_b = 8'(b);
        i_h_sync = hs; i_v_sync = vs; i_data_en = de; i_mode = 2'(m);
        i_valid = 1'b1;
        i_out_ready = next_ready();
        #1;
        while (!o_in_ready) begin
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout in_ready=%0b required 1", o_in_ready);
                i_valid = 1'b0;
                return;
            end
            @(negedge clk);
            i_out_ready = next_ready();
            #1;
        end
        if (vs && !ref_prev_vs) ref_mode = m;
        ref_prev_vs = vs;
        e = model(r, g, b, hs, vs, de, ref_mode);
        if (ey >= 0) begin e.y = ey; e.cb = ecb; e.cr = ecr; end
        if (em >= 0) e.mode = em;
        if (check_lat) e.lat = cyc + 4;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0;
            i_out_ready = next_ready();
        end
    endtask

    logic [29:0] snap;
    bit          prev_stall = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if ({o_y, o_cb, o_cr, o_h_sync, o_v_sync, o_data_en, o_mode, o_valid} !== snap) begin
                    errors++;
                    $display("FAIL stall_hold got %h required %h",
                             {o_y, o_cb, o_cr, o_h_sync, o_v_sync, o_data_en, o_mode, o_valid}, snap);
                end
            end
            if (o_valid && !i_out_ready) begin
                checks++;
                if (o_in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_stall got %b required 0", o_in_ready);
                end
            end
            if (o_valid && i_out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat y=%0d cb=%0d cr=%0d", o_y, o_cb, o_cr);
                end else begin
                    e = q.pop_front();
                    if (o_y !== 8'(e.y) || o_cb !== 8'(e.cb) || o_cr !== 8'(e.cr) ||
                        o_mode !== 2'(e.mode) || o_h_sync !== e.hs || o_v_sync !== e.vs ||
                        o_data_en !== e.de) begin
                        errors++;
                        $display("FAIL beat got y=%0d cb=%0d cr=%0d mode=%0d sb=%b%b%b required y=%0d cb=%0d cr=%0d mode=%0d sb=%b%b%b",
                                 o_y, o_cb, o_cr, o_mode, o_h_sync, o_v_sync, o_data_en,
                                 e.y, e.cb, e.cr, e.mode, e.hs, e.vs, e.de);
                    end
                    if (e.lat >= 0) begin
                        checks++;
                        if (cyc != e.lat) begin
                            errors++;
                            $display("FAIL latency got cycle %0d required %0d", cyc, e.lat);
                        end
                    end
                end
            end
            prev_stall = o_valid && !i_out_ready;
            snap = {o_y, o_cb, o_cr, o_h_sync, o_v_sync, o_data_en, o_mode, o_valid};
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_y !== 8'd0 || o_cb !== 8'd0 || o_cr !== 8'd0 ||
            o_mode !== 2'd0 || o_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got valid=%b y=%0d cb=%0d cr=%0d mode=%0d in_ready=%b required 0 0 0 0 0 1",
                     o_valid, o_y, o_cb, o_cr, o_mode, o_in_ready);
        end

        // Known conversion points and latency with no backpressure.
        check_lat = 1'b1;
        send(255, 255, 255, 1'b0, 1'b1, 1'b1, 0, 235, 128, 128, 0);
        send(0, 0, 0, 1'b0, 1'b1, 1'b1, 0, 16, 128, 128, 0);
        send(255, 0, 0, 1'b1, 1'b1, 1'b0, 0, 63, 102, 240, 0);
        idle(6);
        check_lat = 1'b0;

        // Mode only switches on a v_sync rise between accepted beats.
        send(10, 20, 30, 1'b0, 1'b0, 1'b1, 2, -1, -1, -1, 0);
        send(255, 255, 255, 1'b0, 1'b1, 1'b1, 2, 255, 128, 128, 2);
        send(255, 255, 255, 1'b0, 1'b1, 1'b1, 0, 255, 128, 128, 2);
        send(0, 0, 255, 1'b0, 1'b1, 1'b1, 1, 29, 255, 107, 2);
        send(255, 0, 0, 1'b0, 1'b0, 1'b1, 1, -1, -1, -1, 2);
        send(255, 0, 0, 1'b0, 1'b1, 1'b1, 1, -1, -1, -1, 1);
        send(0, 255, 0, 1'b0, 1'b0, 1'b1, 3);
        send(0, 255, 0, 1'b0, 1'b1, 1'b1, 3, -1, -1, -1, 3);

        // Burst of 16 with a 5-cycle downstream stall in the middle.
        for (int i = 0; i < 16; i++) begin
            if (i == 8) stall_cnt = 5;
            send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 1'($urandom), 1'b1, 1'b1, 3);
        end
        idle(8);

        // Reset with beats in flight after switching to the JPEG matrix.
        send(1, 2, 3, 1'b0, 1'b0, 1'b1, 2);
        send(200, 100, 50, 1'b0, 1'b1, 1'b1, 2);
        send(50, 100, 200, 1'b0, 1'b1, 1'b1, 2);
        send(90, 90, 90, 1'b0, 1'b1, 1'b1, 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_y !== 8'd0 || o_cb !== 8'd0 || o_cr !== 8'd0 || o_mode !== 2'd0) begin
            errors++;
            $display("FAIL reset_in_flight got valid=%b y=%0d cb=%0d cr=%0d mode=%0d required all 0",
                     o_valid, o_y, o_cb, o_cr, o_mode);
        end
        q.delete();
        ref_mode = 0;
        ref_prev_vs = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send(255, 255, 255, 1'b0, 1'b0, 1'b1, 2, 235, 128, 128, 0);
        send(0, 0, 0, 1'b0, 1'b0, 1'b1, 2, 16, 128, 128, 0);
        idle(6);

        // Randomised traffic with backpressure, gaps and frame boundaries.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int c[3];
            for (int k = 0; k < 3; k++) begin
                case ($urandom_range(0, 5))
                    0:       c[k] = 0;
                    1:       c[k] = 255;
                    default: c[k] = $urandom_range(0, 255);
                endcase
            end
            send(c[0], c[1], c[2], 1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom),
                 $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        rand_ready = 1'b0;
        for (int n = 0; n < 200 && q.size() != 0; n++) idle(1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d beats pending required 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
